// File: rtl/resp_nibble_deserializer.sv
// Rebuilds Snitch data responses from a 4-bit link stream.
// Optional read-parity nibble: define RESP_PARITY_EN.
module resp_nibble_deserializer #(
    parameter int DataWidth        = 32,
    parameter int OutstandingDepth = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_push_i,
    input  logic                 req_write_i,
    output logic                 req_ready_o,
    input  logic [3:0]           nib_data_i,
    input  logic                 nib_valid_i,
    output logic                 nib_ready_o,
    output logic [DataWidth-1:0] data_pdata_o,
    output logic                 data_perror_o,
    output logic                 data_pvalid_o,
    input  logic                 data_pready_i,
    output logic                 busy_o
);

    localparam int NibN = DataWidth / 4;
    localparam int CntW = (NibN > 1) ? $clog2(NibN) : 1;
    localparam int PtrW = (OutstandingDepth > 1) ? $clog2(OutstandingDepth) : 1;
    localparam int OccW = $clog2(OutstandingDepth + 1);

    localparam logic [CntW-1:0] LastCnt = CntW'(NibN - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(OutstandingDepth - 1);
    localparam logic [OccW-1:0] FullOcc = OccW'(OutstandingDepth);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_PARITY  = 2'd3;

`ifdef RESP_PARITY_EN
    localparam logic [1:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [1:0] S_AFTER_DATA = S_HOLD;
`endif

    logic [OutstandingDepth-1:0] typ_q;
    logic [PtrW-1:0]             wr_ptr;
    logic [PtrW-1:0]             rd_ptr;
    logic [OccW-1:0]             occ;
    logic                        q_full;
    logic                        q_empty;
    logic                        push;
    logic                        pop;
    logic                        head_write;

    logic [1:0]           state;
    logic [CntW-1:0]      cnt;
    logic [DataWidth-1:0] data_q;
    logic                 err_q;
    logic                 nib_acc;

    assign q_full     = (occ == FullOcc);
    assign q_empty    = (occ == '0);
    assign push       = req_push_i & ~q_full;
    assign pop        = data_pvalid_o & data_pready_i;
    assign head_write = typ_q[rd_ptr];
    assign nib_acc    = nib_valid_i & nib_ready_o;

    // Request-type FIFO; full is judged on current occupancy only.
    always_ff @(posedge clk) begin
        if (rst) begin
            typ_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                typ_q[wr_ptr] <= req_write_i;
                wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_comb begin
        nib_ready_o = 1'b0;
        case (state)
            S_IDLE:    nib_ready_o = ~q_empty;
            S_COLLECT: nib_ready_o = 1'b1;
`ifdef RESP_PARITY_EN
            S_PARITY:  nib_ready_o = 1'b1;
`endif
            default:   nib_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (nib_acc) begin
                        if (head_write) begin
                            data_q <= '0;
                            err_q  <= nib_data_i[0];
                            state  <= S_HOLD;
                        end else begin
                            data_q <= DataWidth'(nib_data_i);
                            err_q  <= 1'b0;
                            if (NibN == 1) begin
                                state <= S_AFTER_DATA;
                            end else begin
                                cnt   <= CntW'(1);
                                state <= S_COLLECT;
                            end
                        end
                    end
                end
                S_COLLECT: begin
                    if (nib_acc) begin
                        data_q[{cnt, 2'b00} +: 4] <= nib_data_i;
                        if (cnt == LastCnt) begin
                            cnt   <= '0;
                            state <= S_AFTER_DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`ifdef RESP_PARITY_EN
                S_PARITY: begin
                    // Sender supplies even parity; any difference flags an error.
                    if (nib_acc) begin
                        err_q <= nib_data_i[0] ^ (^data_q);
                        state <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    if (data_pready_i) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_pdata_o  = data_q;
    assign data_perror_o = err_q;
    assign data_pvalid_o = (state == S_HOLD);
    assign req_ready_o   = ~q_full;
    assign busy_o        = (state != S_IDLE) | ~q_empty;

endmodule

// File: tb/tb_resp_nibble_deserializer.sv
// Directed bench for resp_nibble_deserializer.
// Build with RESP_PARITY_EN to exercise the parity nibble.
module tb_resp_nibble_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_push_i;
    logic        req_write_i;
    logic        req_ready_o;
    logic [3:0]  nib_data_i;
    logic        nib_valid_i;
    logic        nib_ready_o;
    logic [31:0] data_pdata_o;
    logic        data_perror_o;
    logic        data_pvalid_o;
    logic        data_pready_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    resp_nibble_deserializer #(
        .DataWidth(32),
        .OutstandingDepth(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_push_i(req_push_i),
        .req_write_i(req_write_i),
        .req_ready_o(req_ready_o),
        .nib_data_i(nib_data_i),
        .nib_valid_i(nib_valid_i),
        .nib_ready_o(nib_ready_o),
        .data_pdata_o(data_pdata_o),
        .data_perror_o(data_perror_o),
        .data_pvalid_o(data_pvalid_o),
        .data_pready_i(data_pready_i),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic wr);
        req_push_i  = 1'b1;
        req_write_i = wr;
        @(negedge clk);
        req_push_i  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_nib(input logic [3:0] v);
        int t;
        t = 0;
        nib_data_i  = v;
        nib_valid_i = 1'b1;
        while (!nib_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("nib_timeout", 32'(t), 32'd0);
        @(negedge clk);
        nib_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk("pvalid_early", 32'(data_pvalid_o), 32'd0);
            send_nib(w[4*k +: 4]);
        end
    endtask

    task automatic take_resp();
        data_pready_i = 1'b1;
        @(negedge clk);
        data_pready_i = 1'b0;
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] d,
                            input logic e);
        chk({tag, "_pvalid"}, 32'(data_pvalid_o), 32'd1);
        chk({tag, "_pdata"}, data_pdata_o, d);
        chk({tag, "_perror"}, 32'(data_perror_o), 32'(e));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pdata"}, data_pdata_o, 32'd0);
        chk({tag, "_perror"}, 32'(data_perror_o), 32'd0);
        chk({tag, "_pvalid"}, 32'(data_pvalid_o), 32'd0);
        chk({tag, "_nready"}, 32'(nib_ready_o), 32'd0);
        chk({tag, "_rready"}, 32'(req_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        req_push_i    = 1'b0;
        req_write_i   = 1'b0;
        nib_data_i    = 4'h0;
        nib_valid_i   = 1'b0;
        data_pready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_idle("reset");

        // Basic read
        push_req(1'b0);
        chk("rd_busy", 32'(busy_o), 32'd1);
        chk("rd_nready", 32'(nib_ready_o), 32'd1);
        send_word(32'h1234_5678);
        chk_resp("rd", 32'h1234_5678, 1'b0);

        // Backpressure with a nibble offered
        nib_data_i  = 4'hF;
        nib_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_resp("stall", 32'h1234_5678, 1'b0);
            chk("stall_nready", 32'(nib_ready_o), 32'd0);
        end
        nib_valid_i = 1'b0;
        take_resp();
        chk("pop_pvalid", 32'(data_pvalid_o), 32'd0);
        chk("pop_busy", 32'(busy_o), 32'd0);

        // Write acks
        push_req(1'b1);
        send_nib(4'h1);
        chk_resp("wr1", 32'd0, 1'b1);
        take_resp();
        push_req(1'b1);
        send_nib(4'hE);
        chk_resp("wr2", 32'd0, 1'b0);
        take_resp();
        chk("wr_busy", 32'(busy_o), 32'd0);

        // Queue full, push-in-pop-cycle rejected
        push_req(1'b0);
        chk("q1_rready", 32'(req_ready_o), 32'd1);
        push_req(1'b0);
        chk("q2_rready", 32'(req_ready_o), 32'd0);
        push_req(1'b1);
        chk("qfull_rready", 32'(req_ready_o), 32'd0);
        send_word(32'hA5C3_0F96);
        chk_resp("q_rd1", 32'hA5C3_0F96, 1'b0);
        data_pready_i = 1'b1;
        req_push_i    = 1'b1;
        req_write_i   = 1'b1;
        @(negedge clk);
        data_pready_i = 1'b0;
        chk("qpop_rready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_push_i = 1'b0;
        chk("qpush_rready", 32'(req_ready_o), 32'd0);
        send_word(32'h0BAD_F00D);
        chk_resp("q_rd2", 32'h0BAD_F00D, 1'b0);
        take_resp();
        send_nib(4'h3);
        chk_resp("q_wr", 32'd0, 1'b1);
        take_resp();
        chk("q_empty_busy", 32'(busy_o), 32'd0);

        // Nibbles with empty queue
        nib_data_i  = 4'h3;
        nib_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("empty_nready", 32'(nib_ready_o), 32'd0);
            chk("empty_busy", 32'(busy_o), 32'd0);
        end
        nib_valid_i = 1'b0;
        @(negedge clk);

        // Reset mid-word
        push_req(1'b0);
        send_nib(4'h7);
        send_nib(4'h6);
        send_nib(4'h5);
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrst");
        push_req(1'b0);
        send_word(32'h9ABC_DEF0);
        chk_resp("postrst", 32'h9ABC_DEF0, 1'b0);
        take_resp();

`ifdef RESP_PARITY_EN
        push_req(1'b0);
        send_word(32'h0000_0001);
        chk("par_wait", 32'(data_pvalid_o), 32'd0);
        send_nib(4'h1);
        chk_resp("par_ok", 32'h0000_0001, 1'b0);
        take_resp();
        push_req(1'b0);
        send_word(32'h0000_0001);
        send_nib(4'h0);
        chk_resp("par_bad", 32'h0000_0001, 1'b1);
        take_resp();
`endif

        chk("final_busy", 32'(busy_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
